// File: rtl/au_pkg.sv
// Shared types for the arithmetic-unit dispatcher: command encoding,
// the packed command word and the dispatcher state constants.
package au_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    MOVI_REG_B = 2'b00,
    MOVI_MEM   = 2'b01,
    MOVI_IMM   = 2'b10,
    MOVI_ZERO  = 2'b11
  } movi_t;

  typedef struct packed {
    opcode_t     op;
    movi_t       movi;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mem;
    logic [31:0] imm;
  } au_cmd_t;

  localparam int CMD_W = $bits(au_cmd_t);

  typedef logic [1:0] disp_state_t;

  localparam disp_state_t S_IDLE  = 2'd0;
  localparam disp_state_t S_ISSUE = 2'd1;
  localparam disp_state_t S_WAIT  = 2'd2;
  localparam disp_state_t S_RESP  = 2'd3;

endpackage

// File: rtl/au_cmd_fifo.sv
// Synchronous command FIFO holding one au_cmd_t plus tag per entry.
// Push is refused while full even if a pop happens in the same cycle.
module au_cmd_fifo
  import au_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] push_cmd,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [CMD_W-1:0] head_cmd,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  au_cmd_t          cmd_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      cmd_mem[wr_ptr] <= au_cmd_t'(push_cmd);
      tag_mem[wr_ptr] <= push_tag;
    end
  end

  assign head_cmd = cmd_mem[rd_ptr];
  assign head_tag = tag_mem[rd_ptr];

endmodule

// File: rtl/au_dispatcher.sv
// Command-side master for the arithmetic unit: queues commands, issues one
// at a time, holds operands until DATA_VALID and returns tagged results.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops the FIFO head when present
// ISSUE   | ACT pulse to the arithmetic unit, timeout counter cleared
// WAIT    | counting cycles until DATA_VALID or timeout
// RESP    | result held on RES_* until RES_READY
module au_dispatcher
  import au_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP_CODE,
  input  logic [1:0]       CMD_MOVI,
  input  logic [31:0]      CMD_REG_A,
  input  logic [31:0]      CMD_REG_B,
  input  logic [31:0]      CMD_MEM,
  input  logic [31:0]      CMD_IMM,
  input  logic [TAG_W-1:0] CMD_TAG,
  output logic             ACT,
  output logic [1:0]       OP_CODE,
  output logic [1:0]       MOVI,
  output logic [31:0]      REG_A,
  output logic [31:0]      REG_B,
  output logic [31:0]      MEM,
  output logic [31:0]      IMM,
  input  logic [31:0]      DATA,
  input  logic             DATA_VALID,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [31:0]      RES_DATA,
  output logic [TAG_W-1:0] RES_TAG,
  output logic             RES_TIMEOUT
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  disp_state_t      state;
  logic             ready_q;
  au_cmd_t          push_cmd;
  logic [CMD_W-1:0] head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  au_cmd_t          issue_cmd;
  logic [TAG_W-1:0] issue_tag;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;

  always_comb begin
    push_cmd.op   = opcode_t'(CMD_OP_CODE);
    push_cmd.movi = movi_t'(CMD_MOVI);
    push_cmd.a    = CMD_REG_A;
    push_cmd.b    = CMD_REG_B;
    push_cmd.mem  = CMD_MEM;
    push_cmd.imm  = CMD_IMM;
  end

  // ready_q keeps CMD_READY low while reset is applied and for its release edge.
  assign CMD_READY = ready_q && !fifo_full;
  assign fifo_push = CMD_VALID && CMD_READY;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;

  au_cmd_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cmd_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (fifo_push),
    .push_cmd (push_cmd),
    .push_tag (CMD_TAG),
    .pop      (fifo_pop),
    .head_cmd (head_cmd),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      ready_q     <= 1'b0;
      issue_cmd   <= '0;
      issue_tag   <= '0;
      tmo_cnt     <= '0;
      res_data    <= '0;
      res_tag     <= '0;
      res_timeout <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            issue_cmd <= au_cmd_t'(head_cmd);
            issue_tag <= head_tag;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A result arriving in the timeout cycle still counts as a result.
          if (DATA_VALID) begin
            res_data    <= DATA;
            res_tag     <= issue_tag;
            res_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            res_data    <= '0;
            res_tag     <= issue_tag;
            res_timeout <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (RES_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operands stay on the issue register until the next pop; MUL samples late.
  assign ACT         = (state == S_ISSUE);
  assign OP_CODE     = issue_cmd.op;
  assign MOVI        = issue_cmd.movi;
  assign REG_A       = issue_cmd.a;
  assign REG_B       = issue_cmd.b;
  assign MEM         = issue_cmd.mem;
  assign IMM         = issue_cmd.imm;
  assign RES_VALID   = (state == S_RESP);
  assign RES_DATA    = res_data;
  assign RES_TAG     = res_tag;
  assign RES_TIMEOUT = res_timeout;

endmodule
